// File: rtl/ic_qz_block_scheduler.sv
// Block scheduler between the DCT output FIFO and the quantize/zig-zag stage.
// Fetches one 8-row coefficient block at a time and tracks Y/Cb/Cr order per MCU.
module ic_qz_block_scheduler #(
   parameter int ROWS_PER_BLK = 8,
   parameter int MCU_W        = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             cfg_mode,
   input  logic [MCU_W-1:0] cfg_mcu_total,
   input  logic             src_empty,
   output logic             src_rdreq,
   input  logic             qz_hold,
   input  logic             qz_blk_done,
   output logic             row_valid,
   output logic [2:0]       row_idx,
   output logic             tab_sel,
   output logic [1:0]       comp_id,
   output logic             blk_last,
   output logic [MCU_W-1:0] mcu_cnt,
   output logic             busy,
   output logic             frame_done,
   output logic             err
);
   // state       | meaning
   // S_IDLE      | waiting for start
   // S_FETCH     | reading rows of the current block from the FIFO
   // S_WAIT_DONE | block fully read, waiting for quantizer block-done
   // S_NEXT      | advance block/MCU position, pick next component
   // S_DONE      | frame complete, frame_done pulse
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT_DONE, S_NEXT, S_DONE} state_t;

   localparam logic [2:0]       ROW_LAST = 3'(ROWS_PER_BLK - 1);
   localparam logic [MCU_W-1:0] MCU_ONE  = MCU_W'(1);

   state_t           state_q, state_d;
   logic             mode_q, mode_d;
   logic [MCU_W-1:0] total_q, total_d;
   logic [2:0]       row_cnt_q, row_cnt_d;
   logic [2:0]       blk_in_mcu_q, blk_in_mcu_d;
   logic [MCU_W-1:0] mcu_cnt_q, mcu_cnt_d;
   logic [1:0]       comp_id_q, comp_id_d;
   logic             tab_sel_q, tab_sel_d;
   logic             row_valid_q, row_valid_d;
   logic [2:0]       row_idx_q, row_idx_d;
   logic             blk_last_q, blk_last_d;
   logic             frame_done_q, frame_done_d;
   logic             err_q, err_d;
   logic             rdreq_c;
   logic [2:0]       blk_max_c;
   logic [MCU_W-1:0] mcu_inc_c;

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      total_d      = total_q;
      row_cnt_d    = row_cnt_q;
      blk_in_mcu_d = blk_in_mcu_q;
      mcu_cnt_d    = mcu_cnt_q;
      frame_done_d = 1'b0;
      err_d        = err_q;
      rdreq_c      = 1'b0;
      blk_max_c    = mode_q ? 3'd5 : 3'd2;
      mcu_inc_c    = mcu_cnt_q + MCU_ONE;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d       = cfg_mode;
               total_d      = cfg_mcu_total;
               mcu_cnt_d    = '0;
               blk_in_mcu_d = '0;
               row_cnt_d    = '0;
               err_d        = 1'b0;
               if (cfg_mcu_total == '0) begin
                  frame_done_d = 1'b1;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            rdreq_c = ~src_empty & ~qz_hold;
            if (rdreq_c) begin
               if (row_cnt_q == ROW_LAST) begin
                  row_cnt_d = '0;
                  state_d   = S_WAIT_DONE;
               end else begin
                  row_cnt_d = row_cnt_q + 3'd1;
               end
            end
         end
         S_WAIT_DONE: begin
            if (qz_blk_done) state_d = S_NEXT;
         end
         S_NEXT: begin
            if (blk_in_mcu_q == blk_max_c) begin
               blk_in_mcu_d = '0;
               mcu_cnt_d    = mcu_inc_c;
               state_d      = (mcu_inc_c == total_q) ? S_DONE : S_FETCH;
            end else begin
               blk_in_mcu_d = blk_in_mcu_q + 3'd1;
               state_d      = S_FETCH;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d == S_DONE) frame_done_d = 1'b1;

      // Protocol violations are flagged but never disturb sequencing.
      if (qz_blk_done && (state_q == S_IDLE || state_q == S_FETCH)) err_d = 1'b1;
      if (start && state_q != S_IDLE) err_d = 1'b1;
   end

   always_comb begin
      comp_id_d = 2'd0;
      if (!mode_d) begin
         comp_id_d = blk_in_mcu_d[1:0];
      end else if (blk_in_mcu_d == 3'd4) begin
         comp_id_d = 2'd1;
      end else if (blk_in_mcu_d == 3'd5) begin
         comp_id_d = 2'd2;
      end
      tab_sel_d   = (comp_id_d != 2'd0);
      row_valid_d = rdreq_c;
      row_idx_d   = rdreq_c ? row_cnt_q : row_idx_q;
      blk_last_d  = rdreq_c & (row_cnt_q == ROW_LAST);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         mode_q       <= 1'b0;
         total_q      <= '0;
         row_cnt_q    <= '0;
         blk_in_mcu_q <= '0;
         mcu_cnt_q    <= '0;
         comp_id_q    <= '0;
         tab_sel_q    <= 1'b0;
         row_valid_q  <= 1'b0;
         row_idx_q    <= '0;
         blk_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         total_q      <= total_d;
         row_cnt_q    <= row_cnt_d;
         blk_in_mcu_q <= blk_in_mcu_d;
         mcu_cnt_q    <= mcu_cnt_d;
         comp_id_q    <= comp_id_d;
         tab_sel_q    <= tab_sel_d;
         row_valid_q  <= row_valid_d;
         row_idx_q    <= row_idx_d;
         blk_last_q   <= blk_last_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   assign src_rdreq  = rdreq_c;
   assign row_valid  = row_valid_q;
   assign row_idx    = row_idx_q;
   assign tab_sel    = tab_sel_q;
   assign comp_id    = comp_id_q;
   assign blk_last   = blk_last_q;
   assign mcu_cnt    = mcu_cnt_q;
   assign busy       = (state_q != S_IDLE);
   assign frame_done = frame_done_q;
   assign err        = err_q;

endmodule

// File: doc/ic_qz_block_scheduler.md
Name: ic_qz_block_scheduler

Overview:
Sequences 8x8 coefficient blocks from the DCT output FIFO into the quantize/zig-zag stage, one row (8 x 16-bit) per read.
Tracks MCU component order (Y/Cb/Cr), drives the luma/chroma quant-table select, and stalls on source-empty or downstream hold.
Admits one block at a time: waits for the quantizer's block-done before fetching the next block.
Raises a one-cycle frame-done pulse after the programmed number of MCUs.

Parameters:
ROWS_PER_BLK, 8, rows fetched per block; must be a power of two, max 8
MCU_W, 16, width of MCU counter and cfg_mcu_total

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
start  in  1  frame start pulse; ignored unless state IDLE
cfg_mode  in  1  0 = 4:4:4 (Y,Cb,Cr); 1 = 4:2:0 (Y,Y,Y,Y,Cb,Cr); sampled on accepted start
cfg_mcu_total  in  MCU_W  MCUs per frame; sampled on accepted start
src_empty  in  1  DCT output FIFO empty
src_rdreq  out  1  FIFO read request (combinational)
qz_hold  in  1  downstream backpressure; blocks src_rdreq
qz_blk_done  in  1  one-cycle pulse from quantizer: current block fully emitted
row_valid  out  1  FIFO data valid for quantizer; src_rdreq delayed 1 cycle
row_idx  out  3  row number of the row flagged by row_valid
tab_sel  out  1  0 = luma table, 1 = chroma table
comp_id  out  2  0 = Y, 1 = Cb, 2 = Cr
blk_last  out  1  high with row_valid on the final row of a block
mcu_cnt  out  MCU_W  completed MCUs in the current frame
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse at frame end
err  out  1  sticky protocol error; cleared on accepted start

Behaviour:
- Reset: state IDLE; all registered outputs 0, including row_valid, row_idx, tab_sel, comp_id, blk_last, mcu_cnt, frame_done and err; internal row/blk counters 0. Reset mid-frame abandons the frame with no frame_done.
- States:
  - IDLE -> FETCH on start with cfg_mcu_total != 0. Latches cfg, clears mcu_cnt, blk_in_mcu, row counter and err.
  - IDLE, start with cfg_mcu_total == 0: frame_done pulses next cycle, stay IDLE.
  - FETCH: src_rdreq = ~src_empty & ~qz_hold. Each read increments the row counter. The read with row counter == ROWS_PER_BLK-1 wraps the counter to 0 and goes to WAIT_DONE.
  - WAIT_DONE: src_rdreq = 0. On qz_blk_done -> NEXT.
  - NEXT (1 cycle):
    - blk_in_mcu at last (2 for mode 0, 5 for mode 1): blk_in_mcu <= 0, mcu_cnt++. If the new mcu_cnt == cfg_mcu_total -> DONE, else FETCH.
    - Otherwise blk_in_mcu++ -> FETCH.
  - DONE: frame_done = 1 for one cycle -> IDLE. mcu_cnt holds its value until the next start.
- Component map:
  - mode 0: blk 0/1/2 -> comp 0/1/2.
  - mode 1: blk 0-3 -> comp 0, blk 4 -> comp 1, blk 5 -> comp 2.
  - tab_sel = (comp_id != 0).
- tab_sel and comp_id update in NEXT and stay stable for the whole block, including WAIT_DONE.
- Latency: row_valid, row_idx and blk_last are registered one cycle after src_rdreq. A stall cycle produces row_valid = 0 and inserts no bubble-row.
- Priority: src_empty or qz_hold asserted mid-block freezes the row counter; fetch resumes at the same row.
- Errors (set err, state unaffected):
  - qz_blk_done in FETCH or IDLE: ignored.
  - start while busy: ignored.

Test Plan:
- mode 0, mcu_total=1, FIFO never empty, qz_blk_done 4 cycles after each WAIT_DONE entry -> 24 src_rdreq. comp_id 0,1,2 per 8 rows; tab_sel 0,1,1. blk_last on rows 7,15,23. frame_done once. mcu_cnt=1. err=0.
- mode 1, mcu_total=2 -> 12 blocks, comp_id sequence Y,Y,Y,Y,Cb,Cr twice. mcu_cnt steps 1 then 2. frame_done after the 12th qz_blk_done + 2 cycles.
- src_empty toggling every other cycle plus qz_hold high for 5 cycles at row 3 -> no rdreq while either is high. row_idx stays contiguous 0..7. row_valid exactly 1 cycle after each rdreq.
- start with cfg_mcu_total=0 -> no rdreq, frame_done next cycle, busy stays 0.
- qz_blk_done pulsed at row 2 of a block -> err=1, rows 3..7 still fetched. start in the same frame ignored. err cleared by the next accepted start.
- reset_n low at block 4 (mode 1) -> next cycle all outputs 0, state IDLE, no frame_done. A new start runs a clean frame.
